// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and helpers for the round-robin pipeline scheduler.
//   DEF_* are the default parameter values used by pipe_rr_sched and
//   pipe_rsp_fifo. clog2 is a constant function used to size pointers,
//   ids and counters.
// ---------------------------------------------------------------------------
package pipe_pkg;

   // Smallest r with (1 << r) >= v; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int DEF_N     = 10;                // operand/result width
   localparam int DEF_NREQ  = 4;                 // number of requesters
   localparam int DEF_LAT   = 3;                 // datapath latency (edges)
   localparam int DEF_DEPTH = 4;                 // response FIFO entries / credit limit
   localparam int DEF_IDW   = clog2(DEF_NREQ);   // requester id width

endpackage

// File: rtl/pipe_rsp_fifo.sv
// ---------------------------------------------------------------------------
// pipe_rsp_fifo
//   Synchronous FIFO holding {id, result} responses. DEPTH must be a power
//   of two (>= 2) so the read/write pointers wrap naturally.
//   Ports:
//     clk, rst_n  clock, async active-low reset (pointers and count only)
//     push, wdata write request and data
//     pop         read request; ignored when empty
//     rdata       head entry (valid when !empty)
//     full, empty occupancy flags
//     count       number of stored entries (0..DEPTH)
//   A push into a full FIFO is accepted only if a pop happens on the same
//   edge; otherwise it is dropped (the caller guarantees this never occurs).
// ---------------------------------------------------------------------------
module pipe_rsp_fifo
   import pipe_pkg::*;
#(
   parameter int W     = DEF_IDW + DEF_N,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (cnt == '0);
   assign full    = (cnt == FULL_CNT);
   assign count   = cnt;
   assign rdata   = mem[rd_ptr];
   assign pop_ok  = pop & ~empty;
   // Full + pop frees the head slot on this same edge, so the push may land.
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pipe_rr_sched.sv
// ---------------------------------------------------------------------------
// pipe_rr_sched
//   Round-robin scheduler sharing one external LAT-stage arithmetic pipeline
//   among NREQ requesters. At most one op is issued per cycle; a valid/tag
//   shift register follows each op through the pipeline (which has neither
//   reset nor valid) and the result is written with its requester id into a
//   response FIFO. Credits (= free FIFO slots not yet claimed by in-flight
//   ops) stop issue before the FIFO could overflow.
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both high. ready may depend combinationally on valid (req_ready is a
//   grant computed from req_valid); a producer holds its payload stable
//   while valid & !ready. rsp_valid/rsp_ready follow the same rule.
//
//   Ports:
//     clk, rst_n       clock, async active-low reset
//     req_valid[NREQ]  per-requester op valid
//     req_ready[NREQ]  one-hot grant
//     req_a..req_d     packed operands, requester i at [i*N +: N]
//     dp_a..dp_d       operands to the shared pipeline (0 when no grant)
//     dp_f             pipeline result, LAT edges after issue
//     rsp_valid/ready  response handshake
//     rsp_id, rsp_data requester id and result at the FIFO head
//     busy             op in flight or FIFO not empty
// ---------------------------------------------------------------------------
module pipe_rr_sched
   import pipe_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int NREQ  = DEF_NREQ,
   parameter int LAT   = DEF_LAT,
   parameter int DEPTH = DEF_DEPTH,
   parameter int IDW   = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ*N-1:0] req_c,
   input  logic [NREQ*N-1:0] req_d,
   output logic [N-1:0]      dp_a,
   output logic [N-1:0]      dp_b,
   output logic [N-1:0]      dp_c,
   output logic [N-1:0]      dp_d,
   input  logic [N-1:0]      dp_f,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [N-1:0]      rsp_data,
   output logic              busy
);

   localparam int CW = clog2(DEPTH + 1);
   localparam int AW = clog2(DEPTH);

   logic [IDW-1:0]  ptr;            // last granted requester
   logic [CW-1:0]   credits;
   logic [LAT-1:0]  sr_vld;         // op in pipeline stage i
   logic [IDW-1:0]  sr_id [LAT];    // requester id of that op

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_id;
   logic            xfer;
   logic            pop;

   logic            fifo_push;
   logic [IDW+N-1:0] fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW:0]     fifo_count;

   // Round-robin search starting just above ptr. Gated by rst_n so no
   // grant is shown while reset is held.
   always_comb begin
      int idx;
      logic found;
      grant  = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      if (rst_n && credits != '0) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               gnt_id     = IDW'(idx);
            end
         end
      end
   end

   // A grant is only ever given to a valid requester, so any grant is a transfer.
   assign xfer      = |grant;
   assign req_ready = grant;

   // Operand mux: one-hot grant, so OR-ing the selected slices is exact.
   always_comb begin
      dp_a = '0;
      dp_b = '0;
      dp_c = '0;
      dp_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            dp_a = dp_a | req_a[i*N +: N];
            dp_b = dp_b | req_b[i*N +: N];
            dp_c = dp_c | req_c[i*N +: N];
            dp_d = dp_d | req_d[i*N +: N];
         end
      end
   end

   assign pop = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= IDW'(NREQ - 1);     // req0 wins the first search
         credits <= CW'(DEPTH);
         sr_vld  <= '0;
         for (int i = 0; i < LAT; i++) sr_id[i] <= '0;
      end else begin
         if (xfer) ptr <= gnt_id;
         case ({xfer, pop})
            2'b10:   credits <= credits - CW'(1);
            2'b01:   credits <= credits + CW'(1);
            default: credits <= credits;
         endcase
         for (int i = LAT - 1; i > 0; i--) begin
            sr_vld[i] <= sr_vld[i-1];
            sr_id[i]  <= sr_id[i-1];
         end
         sr_vld[0] <= xfer;
         sr_id[0]  <= gnt_id;
      end
   end

   // dp_f belongs to the op in the last stage; capture it on the next edge.
   assign fifo_push = sr_vld[LAT-1];

   pipe_rsp_fifo #(
      .W     (IDW + N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata ({sr_id[LAT-1], dp_f}),
      .pop   (rsp_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rsp_valid = ~fifo_empty;
   assign rsp_id    = fifo_rdata[IDW+N-1 -: IDW];
   assign rsp_data  = fifo_rdata[N-1:0];
   assign busy      = (|sr_vld) | ~fifo_empty;

   // Credits make an unmatched write into a full FIFO impossible, and every
   // slot is accounted for exactly once.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(fifo_push && fifo_full && !pop));
         assert ($countones(sr_vld) + int'(fifo_count) + int'(credits) == DEPTH);
      end
   end

endmodule
